// File: rtl/rename_reg_file.sv
// -----------------------------------------------------------------------------
// rename_reg_file
//
// Architectural register file with a rename (dependency) table, NUM_RD
// combinational read channels and optional checkpoint slots for branch
// recovery. Decode/issue reads operands through the read channels and records
// the ROB tag of each new destination. The ROB commits results through the
// commit port and answers in-flight value queries in the same cycle.
//
// Optional feature macro: RENAME_SNAPSHOT_EN
//   defined     -> NUM_SNAP checkpoint slots of the dependency table, with
//                  snap_save / snap_restore handling.
//   not defined -> no checkpoint storage; snap_* inputs are ignored.
//
// Ports
//   clk_in, rst_in      clock and synchronous active-high reset
//   rdy_in              low freezes all state (outputs still track inputs)
//   rob_clear           flush: drops every dependency (live and checkpointed)
//   commit_*            ROB commit: value write plus conditional busy clear
//   rename_*            new producer tag for a destination register
//   rd_id               packed read indices, channel k at [k*REG_W +: REG_W]
//   rd_val/has_dep/dep  per-channel operand result
//   rob_qry_id          tag query to ROB (same as rd_dep)
//   rob_qry_ready/val   same-cycle ROB answer per channel
//   snap_save/_slot     save a checkpoint of the dependency table
//   snap_restore/_slot  restore a checkpoint of the dependency table
// -----------------------------------------------------------------------------

`ifndef ROB_WIDTH_BIT
`define ROB_WIDTH_BIT 4
`endif

module rename_reg_file #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int REG_W    = $clog2(NUM_REGS),
    parameter int ROB_W    = `ROB_WIDTH_BIT,
    parameter int NUM_RD   = 2,
    parameter int NUM_SNAP = 4,
    parameter int SNAP_W   = $clog2(NUM_SNAP)
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     rob_clear,

    input  logic                     commit_valid,
    input  logic [REG_W-1:0]         commit_reg_id,
    input  logic [XLEN-1:0]          commit_val,
    input  logic [ROB_W-1:0]         commit_rob_id,

    input  logic                     rename_valid,
    input  logic [REG_W-1:0]         rename_reg_id,
    input  logic [ROB_W-1:0]         rename_rob_id,

    input  logic [NUM_RD*REG_W-1:0]  rd_id,
    output logic [NUM_RD*XLEN-1:0]   rd_val,
    output logic [NUM_RD-1:0]        rd_has_dep,
    output logic [NUM_RD*ROB_W-1:0]  rd_dep,

    output logic [NUM_RD*ROB_W-1:0]  rob_qry_id,
    input  logic [NUM_RD-1:0]        rob_qry_ready,
    input  logic [NUM_RD*XLEN-1:0]   rob_qry_val,

    input  logic                     snap_save,
    input  logic [SNAP_W-1:0]        snap_save_slot,
    input  logic                     snap_restore,
    input  logic [SNAP_W-1:0]        snap_restore_slot
);

    typedef logic [NUM_REGS-1:0][ROB_W-1:0] dep_tab_t;
    typedef logic [NUM_REGS-1:0]            busy_tab_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [XLEN-1:0] regs [NUM_REGS];
    dep_tab_t        dep,  dep_n;
    busy_tab_t       busy, busy_n;

`ifdef RENAME_SNAPSHOT_EN
    dep_tab_t        s_dep    [NUM_SNAP];
    dep_tab_t        s_dep_n  [NUM_SNAP];
    busy_tab_t       s_busy   [NUM_SNAP];
    busy_tab_t       s_busy_n [NUM_SNAP];
`else
    // Snapshot inputs have no function in this build.
    logic unused_snap;
    assign unused_snap = ^{snap_save, snap_save_slot, snap_restore, snap_restore_slot};
`endif

    // Register 0 is hard-wired: commits and renames to it are dropped, so
    // regs[0], dep[0] and busy[0] stay zero forever after reset.
    logic commit_eff;
    logic rename_eff;
    logic rename_hits_commit;

    assign commit_eff         = commit_valid && (commit_reg_id != '0);
    assign rename_eff         = rename_valid && (rename_reg_id != '0);
    assign rename_hits_commit = rename_eff && (rename_reg_id == commit_reg_id);

    // ------------------------------------------------------------------
    // Next-state of the dependency tables
    // ------------------------------------------------------------------
    // NOTE: every variable driven here gets a default before any branch,
    // otherwise paths that skip an assignment would infer latches.
    always_comb begin
        dep_n  = dep;
        busy_n = busy;

`ifdef RENAME_SNAPSHOT_EN
        // Commit clear reaches every checkpoint holding the retiring tag,
        // so a later restore can never resurrect a retired producer.
        for (int s = 0; s < NUM_SNAP; s++) begin
            s_dep_n[s]  = s_dep[s];
            s_busy_n[s] = s_busy[s];
            if (commit_eff && (s_dep[s][commit_reg_id] == commit_rob_id)) begin
                s_busy_n[s][commit_reg_id] = 1'b0;
            end
        end
`endif

        if (rob_clear) begin
            dep_n  = '0;
            busy_n = '0;
`ifdef RENAME_SNAPSHOT_EN
            for (int s = 0; s < NUM_SNAP; s++) begin
                s_busy_n[s] = '0;
            end
`endif
        end
`ifdef RENAME_SNAPSHOT_EN
        else if (snap_restore) begin
            // Restore first, then retire this cycle's commit against the
            // restored mapping. Rename and save are dropped this cycle.
            dep_n  = s_dep[snap_restore_slot];
            busy_n = s_busy[snap_restore_slot];
            if (commit_eff && (dep_n[commit_reg_id] == commit_rob_id)) begin
                busy_n[commit_reg_id] = 1'b0;
            end
        end
`endif
        else begin
            // A same-cycle rename of the committing register installs a newer
            // producer, so the commit must not clear its busy bit.
            if (commit_eff && (dep[commit_reg_id] == commit_rob_id) && !rename_hits_commit) begin
                busy_n[commit_reg_id] = 1'b0;
            end
            if (rename_eff) begin
                dep_n[rename_reg_id]  = rename_rob_id;
                busy_n[rename_reg_id] = 1'b1;
            end
`ifdef RENAME_SNAPSHOT_EN
            // The checkpoint captures the table as it will be after this edge.
            if (snap_save) begin
                s_dep_n[snap_save_slot]  = dep_n;
                s_busy_n[snap_save_slot] = busy_n;
            end
`endif
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    // NOTE: state uses non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            // NOTE: the register array is reset explicitly because software
            // observes it as architectural state; this costs a reset on
            // every entry instead of a plain RAM.
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            dep  <= '0;
            busy <= '0;
`ifdef RENAME_SNAPSHOT_EN
            for (int s = 0; s < NUM_SNAP; s++) begin
                s_dep[s]  <= '0;
                s_busy[s] <= '0;
            end
`endif
        end else if (rdy_in) begin
            // The value write happens in every mode, including flush and restore.
            if (commit_eff) begin
                regs[commit_reg_id] <= commit_val;
            end
            dep  <= dep_n;
            busy <= busy_n;
`ifdef RENAME_SNAPSHOT_EN
            for (int s = 0; s < NUM_SNAP; s++) begin
                s_dep[s]  <= s_dep_n[s];
                s_busy[s] <= s_busy_n[s];
            end
`endif
        end
    end

    // ------------------------------------------------------------------
    // Read channels
    // ------------------------------------------------------------------
    // Resolution order per channel: idle register, same-cycle commit
    // forward, ROB answer, otherwise report the outstanding dependency.
    always_comb begin
        rd_val     = '0;
        rd_has_dep = '0;
        rd_dep     = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            rd_dep[k*ROB_W +: ROB_W] = dep[rd_id[k*REG_W +: REG_W]];
            if (!busy[rd_id[k*REG_W +: REG_W]]) begin
                rd_val[k*XLEN +: XLEN] = regs[rd_id[k*REG_W +: REG_W]];
            end else if (commit_valid && (commit_rob_id == dep[rd_id[k*REG_W +: REG_W]])) begin
                rd_val[k*XLEN +: XLEN] = commit_val;
            end else if (rob_qry_ready[k]) begin
                rd_val[k*XLEN +: XLEN] = rob_qry_val[k*XLEN +: XLEN];
            end else begin
                rd_val[k*XLEN +: XLEN] = regs[rd_id[k*REG_W +: REG_W]];
                rd_has_dep[k]          = 1'b1;
            end
        end
    end

    assign rob_qry_id = rd_dep;

endmodule

// File: tb/tb_rename_reg_file.sv
// -----------------------------------------------------------------------------
// tb_rename_reg_file
//
// Directed self-checking bench for rename_reg_file (default parameters,
// two read channels). Inputs change #1 after the rising edge; outputs are
// sampled mid-cycle. Checkpoint scenarios run only when RENAME_SNAPSHOT_EN
// is defined.
// -----------------------------------------------------------------------------

module tb_rename_reg_file;

    localparam int XLEN   = 32;
    localparam int REG_W  = 5;
    localparam int ROB_W  = 4;
    localparam int NUM_RD = 2;
    localparam int SNAP_W = 2;

    logic                    clk_in = 1'b0;
    logic                    rst_in;
    logic                    rdy_in;
    logic                    rob_clear;
    logic                    commit_valid;
    logic [REG_W-1:0]        commit_reg_id;
    logic [XLEN-1:0]         commit_val;
    logic [ROB_W-1:0]        commit_rob_id;
    logic                    rename_valid;
    logic [REG_W-1:0]        rename_reg_id;
    logic [ROB_W-1:0]        rename_rob_id;
    logic [NUM_RD*REG_W-1:0] rd_id;
    logic [NUM_RD*XLEN-1:0]  rd_val;
    logic [NUM_RD-1:0]       rd_has_dep;
    logic [NUM_RD*ROB_W-1:0] rd_dep;
    logic [NUM_RD*ROB_W-1:0] rob_qry_id;
    logic [NUM_RD-1:0]       rob_qry_ready;
    logic [NUM_RD*XLEN-1:0]  rob_qry_val;
    logic                    snap_save;
    logic [SNAP_W-1:0]       snap_save_slot;
    logic                    snap_restore;
    logic [SNAP_W-1:0]       snap_restore_slot;

    int n_tests = 0;
    int n_fail  = 0;

    rename_reg_file #(
        .XLEN(XLEN), .NUM_REGS(32), .REG_W(REG_W), .ROB_W(ROB_W),
        .NUM_RD(NUM_RD), .NUM_SNAP(4), .SNAP_W(SNAP_W)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rob_clear(rob_clear),
        .commit_valid(commit_valid), .commit_reg_id(commit_reg_id),
        .commit_val(commit_val), .commit_rob_id(commit_rob_id),
        .rename_valid(rename_valid), .rename_reg_id(rename_reg_id),
        .rename_rob_id(rename_rob_id),
        .rd_id(rd_id), .rd_val(rd_val), .rd_has_dep(rd_has_dep), .rd_dep(rd_dep),
        .rob_qry_id(rob_qry_id), .rob_qry_ready(rob_qry_ready), .rob_qry_val(rob_qry_val),
        .snap_save(snap_save), .snap_save_slot(snap_save_slot),
        .snap_restore(snap_restore), .snap_restore_slot(snap_restore_slot)
    );

    always #5 clk_in = ~clk_in;

    // Channel field accessors for readability.
    function automatic logic [XLEN-1:0] val_of(input int k);
        return rd_val[k*XLEN +: XLEN];
    endfunction
    function automatic logic [ROB_W-1:0] dep_of(input int k);
        return rd_dep[k*ROB_W +: ROB_W];
    endfunction
    function automatic logic [ROB_W-1:0] qry_of(input int k);
        return rob_qry_id[k*ROB_W +: ROB_W];
    endfunction

    task automatic idle();
        rob_clear     = 1'b0;
        commit_valid  = 1'b0;
        commit_reg_id = '0;
        commit_val    = '0;
        commit_rob_id = '0;
        rename_valid  = 1'b0;
        rename_reg_id = '0;
        rename_rob_id = '0;
        rob_qry_ready = '0;
        rob_qry_val   = '0;
        snap_save     = 1'b0;
        snap_save_slot    = '0;
        snap_restore      = 1'b0;
        snap_restore_slot = '0;
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
        idle();
    endtask

    task automatic do_rename(input logic [REG_W-1:0] r, input logic [ROB_W-1:0] t);
        rename_valid  = 1'b1;
        rename_reg_id = r;
        rename_rob_id = t;
    endtask

    task automatic do_commit(input logic [REG_W-1:0] r, input logic [XLEN-1:0] v,
                             input logic [ROB_W-1:0] t);
        commit_valid  = 1'b1;
        commit_reg_id = r;
        commit_val    = v;
        commit_rob_id = t;
    endtask

    // --------------------------------------------------------------------
    task automatic test_reset();
        rst_in = 1'b1;
        rdy_in = 1'b1;
        idle();
        rd_id = {5'd31, 5'd5};
        step();
        step();
        rst_in = 1'b0;
        #3;
        n_tests++; if (val_of(0) !== 32'h0) begin n_fail++; $display("FAIL reset_val0: got %h expected %h", val_of(0), 32'h0); end
        n_tests++; if (rd_has_dep !== 2'b00) begin n_fail++; $display("FAIL reset_has_dep: got %b expected %b", rd_has_dep, 2'b00); end
        n_tests++; if (rd_dep !== '0) begin n_fail++; $display("FAIL reset_dep: got %h expected 0", rd_dep); end
        n_tests++; if (rob_qry_id !== '0) begin n_fail++; $display("FAIL reset_qry_id: got %h expected 0", rob_qry_id); end
        n_tests++; if (val_of(1) !== 32'h0) begin n_fail++; $display("FAIL reset_val1: got %h expected %h", val_of(1), 32'h0); end
    endtask

    // --------------------------------------------------------------------
    task automatic test_rename_commit();
        rd_id = {5'd5, 5'd5};
        do_rename(5'd5, 4'd3);
        #3;
        // Same-cycle rename is not yet visible.
        n_tests++; if (rd_has_dep[0] !== 1'b0) begin n_fail++; $display("FAIL rename_same_cycle_old: got %b expected %b", rd_has_dep[0], 1'b0); end
        step();
        #3;
        n_tests++; if (rd_has_dep[0] !== 1'b1) begin n_fail++; $display("FAIL rename_has_dep: got %b expected %b", rd_has_dep[0], 1'b1); end
        n_tests++; if (dep_of(0) !== 4'd3) begin n_fail++; $display("FAIL rename_dep: got %0d expected %0d", dep_of(0), 3); end
        n_tests++; if (qry_of(1) !== 4'd3) begin n_fail++; $display("FAIL rename_qry_id: got %0d expected %0d", qry_of(1), 3); end
        do_commit(5'd5, 32'hDEADBEEF, 4'd3);
        #1;
        n_tests++; if (val_of(0) !== 32'hDEADBEEF) begin n_fail++; $display("FAIL commit_fwd_val: got %h expected %h", val_of(0), 32'hDEADBEEF); end
        n_tests++; if (rd_has_dep[0] !== 1'b0) begin n_fail++; $display("FAIL commit_fwd_has_dep: got %b expected %b", rd_has_dep[0], 1'b0); end
        step();
        #3;
        n_tests++; if (rd_has_dep !== 2'b00) begin n_fail++; $display("FAIL commit_busy_clear: got %b expected %b", rd_has_dep, 2'b00); end
        n_tests++; if (val_of(1) !== 32'hDEADBEEF) begin n_fail++; $display("FAIL commit_regs_val: got %h expected %h", val_of(1), 32'hDEADBEEF); end
    endtask

    // --------------------------------------------------------------------
    task automatic test_rob_query();
        do_rename(5'd6, 4'd5);
        step();
        rd_id         = {5'd6, 5'd5};
        rob_qry_ready = 2'b10;
        rob_qry_val   = {32'h0000_1234, 32'hFFFF_FFFF};
        #3;
        n_tests++; if (val_of(1) !== 32'h1234) begin n_fail++; $display("FAIL rob_qry_val: got %h expected %h", val_of(1), 32'h1234); end
        n_tests++; if (rd_has_dep[1] !== 1'b0) begin n_fail++; $display("FAIL rob_qry_has_dep: got %b expected %b", rd_has_dep[1], 1'b0); end
        // Channel 0 reads an idle register; its ready bit must not matter.
        n_tests++; if (val_of(0) !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rob_qry_idle_ch: got %h expected %h", val_of(0), 32'hDEADBEEF); end
        rob_qry_ready = 2'b01;
        #1;
        n_tests++; if (rd_has_dep[1] !== 1'b1) begin n_fail++; $display("FAIL rob_qry_wrong_ch: got %b expected %b", rd_has_dep[1], 1'b1); end
        rob_qry_ready = 2'b00;
        do_commit(5'd6, 32'h66, 4'd9);
        step();
        #3;
        // Tag mismatch: value written, dependency kept.
        n_tests++; if (rd_has_dep[1] !== 1'b1) begin n_fail++; $display("FAIL mismatch_keeps_busy: got %b expected %b", rd_has_dep[1], 1'b1); end
        n_tests++; if (val_of(1) !== 32'h66) begin n_fail++; $display("FAIL mismatch_regs_val: got %h expected %h", val_of(1), 32'h66); end
        n_tests++; if (dep_of(1) !== 4'd5) begin n_fail++; $display("FAIL mismatch_dep: got %0d expected %0d", dep_of(1), 5); end
    endtask

    // --------------------------------------------------------------------
    task automatic test_commit_rename_same();
        do_rename(5'd7, 4'd2);
        step();
        do_commit(5'd7, 32'h77, 4'd2);
        do_rename(5'd7, 4'd6);
        step();
        rd_id = {5'd5, 5'd7};
        #3;
        n_tests++; if (rd_has_dep[0] !== 1'b1) begin n_fail++; $display("FAIL same_has_dep: got %b expected %b", rd_has_dep[0], 1'b1); end
        n_tests++; if (dep_of(0) !== 4'd6) begin n_fail++; $display("FAIL same_dep: got %0d expected %0d", dep_of(0), 6); end
        n_tests++; if (val_of(0) !== 32'h77) begin n_fail++; $display("FAIL same_regs_val: got %h expected %h", val_of(0), 32'h77); end
    endtask

    // --------------------------------------------------------------------
    task automatic test_x0();
        rd_id = {5'd0, 5'd0};
        do_rename(5'd0, 4'd1);
        do_commit(5'd0, 32'h5, 4'd1);
        #3;
        n_tests++; if (val_of(0) !== 32'h0) begin n_fail++; $display("FAIL x0_same_cycle_val: got %h expected %h", val_of(0), 32'h0); end
        step();
        #3;
        n_tests++; if (val_of(0) !== 32'h0) begin n_fail++; $display("FAIL x0_val: got %h expected %h", val_of(0), 32'h0); end
        n_tests++; if (rd_has_dep !== 2'b00) begin n_fail++; $display("FAIL x0_has_dep: got %b expected %b", rd_has_dep, 2'b00); end
        n_tests++; if (dep_of(1) !== 4'd0) begin n_fail++; $display("FAIL x0_dep: got %0d expected %0d", dep_of(1), 0); end
    endtask

    // --------------------------------------------------------------------
    task automatic test_rdy_freeze();
        rdy_in = 1'b0;
        rd_id  = {5'd9, 5'd7};
        do_rename(5'd9, 4'd8);
        do_commit(5'd7, 32'hABCD, 4'd6);
        #3;
        // Forwarding remains combinational while frozen.
        n_tests++; if (val_of(0) !== 32'hABCD) begin n_fail++; $display("FAIL frozen_fwd_val: got %h expected %h", val_of(0), 32'hABCD); end
        step();
        step();
        #3;
        n_tests++; if (rd_has_dep[0] !== 1'b1) begin n_fail++; $display("FAIL frozen_busy_kept: got %b expected %b", rd_has_dep[0], 1'b1); end
        n_tests++; if (val_of(0) !== 32'h77) begin n_fail++; $display("FAIL frozen_regs_kept: got %h expected %h", val_of(0), 32'h77); end
        n_tests++; if (rd_has_dep[1] !== 1'b0) begin n_fail++; $display("FAIL frozen_no_rename: got %b expected %b", rd_has_dep[1], 1'b0); end
        rdy_in = 1'b1;
        do_rename(5'd9, 4'd8);
        step();
        #3;
        n_tests++; if (rd_has_dep[1] !== 1'b1) begin n_fail++; $display("FAIL resume_has_dep: got %b expected %b", rd_has_dep[1], 1'b1); end
        n_tests++; if (dep_of(1) !== 4'd8) begin n_fail++; $display("FAIL resume_dep: got %0d expected %0d", dep_of(1), 8); end
    endtask

    // --------------------------------------------------------------------
    task automatic test_rob_clear();
        rob_clear = 1'b1;
        do_commit(5'd10, 32'h55, 4'd0);
        do_rename(5'd11, 4'd3);
        step();
        rd_id = {5'd9, 5'd7};
        #3;
        n_tests++; if (rd_has_dep !== 2'b00) begin n_fail++; $display("FAIL clear_has_dep: got %b expected %b", rd_has_dep, 2'b00); end
        n_tests++; if (rd_dep !== '0) begin n_fail++; $display("FAIL clear_dep: got %h expected 0", rd_dep); end
        rd_id = {5'd11, 5'd10};
        #1;
        n_tests++; if (val_of(0) !== 32'h55) begin n_fail++; $display("FAIL clear_commit_write: got %h expected %h", val_of(0), 32'h55); end
        n_tests++; if (rd_has_dep[1] !== 1'b0 || dep_of(1) !== 4'd0) begin n_fail++; $display("FAIL clear_rename_ignored: got %b/%0d expected 0/0", rd_has_dep[1], dep_of(1)); end
    endtask

`ifdef RENAME_SNAPSHOT_EN
    // --------------------------------------------------------------------
    task automatic test_snapshot();
        rd_id = {5'd4, 5'd3};
        do_rename(5'd3, 4'd4);
        step();
        snap_save = 1'b1; snap_save_slot = 2'd1;
        step();
        do_rename(5'd3, 4'd7);
        step();
        do_commit(5'd3, 32'h33, 4'd4);
        step();
        #3;
        n_tests++; if (rd_has_dep[0] !== 1'b1 || dep_of(0) !== 4'd7) begin n_fail++; $display("FAIL snap_live_busy: got %b/%0d expected 1/7", rd_has_dep[0], dep_of(0)); end
        snap_restore = 1'b1; snap_restore_slot = 2'd1;
        step();
        #3;
        n_tests++; if (rd_has_dep[0] !== 1'b0) begin n_fail++; $display("FAIL snap_restore_clear: got %b expected %b", rd_has_dep[0], 1'b0); end
        n_tests++; if (val_of(0) !== 32'h33) begin n_fail++; $display("FAIL snap_restore_val: got %h expected %h", val_of(0), 32'h33); end
        n_tests++; if (dep_of(0) !== 4'd4) begin n_fail++; $display("FAIL snap_restore_dep: got %0d expected %0d", dep_of(0), 4); end
        do_rename(5'd3, 4'd5);
        snap_save = 1'b1; snap_save_slot = 2'd2;
        step();
        do_rename(5'd4, 4'd2);
        step();
        rob_clear = 1'b1;
        snap_restore = 1'b1; snap_restore_slot = 2'd2;
        step();
        #3;
        n_tests++; if (rd_has_dep !== 2'b00) begin n_fail++; $display("FAIL snap_clear_restore: got %b expected %b", rd_has_dep, 2'b00); end
        snap_restore = 1'b1; snap_restore_slot = 2'd2;
        step();
        #3;
        n_tests++; if (rd_has_dep[0] !== 1'b0) begin n_fail++; $display("FAIL snap_cleared_slot: got %b expected %b", rd_has_dep[0], 1'b0); end
        do_rename(5'd4, 4'd2);
        step();
        snap_restore = 1'b1; snap_restore_slot = 2'd3;
        step();
        #3;
        n_tests++; if (rd_has_dep[1] !== 1'b0 || dep_of(1) !== 4'd0) begin n_fail++; $display("FAIL snap_unsaved_slot: got %b/%0d expected 0/0", rd_has_dep[1], dep_of(1)); end
    endtask
`endif

    initial begin
        test_reset();
        test_rename_commit();
        test_rob_query();
        test_commit_rename_same();
        test_x0();
        test_rdy_freeze();
        test_rob_clear();
`ifdef RENAME_SNAPSHOT_EN
        test_snapshot();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rename_reg_file.md
# rename_reg_file

Parametrised architectural register file with a rename (dependency) table, N combinational read channels and optional checkpoint slots for branch recovery. It sits between decode/issue, which reads operands and records the destination ROB tag, and the ReorderBuffer, which commits results and answers in-flight value queries. It generalises the single-issue register file:
- configurable read-port count and table depth
- same-cycle commit forwarding
- correct x0 handling
- checkpoint save/restore of the dependency table

## Interface
Parameters:
- `XLEN`, 32, data width
- `NUM_REGS`, 32, architectural registers; `REG_W = $clog2(NUM_REGS)`
- `ROB_W`, `ROB_WIDTH_BIT`, ROB tag width
- `NUM_RD`, 2, read channels
- `NUM_SNAP`, 4, checkpoint slots; `SNAP_W = $clog2(NUM_SNAP)`

Ports:
- `clk_in` in 1: clock, single domain
- `rst_in` in 1: synchronous, active-high reset
- `rdy_in` in 1: low = freeze all state
- `rob_clear` in 1: flush; clears all dependencies
- `commit_valid` in 1, `commit_reg_id` in REG_W, `commit_val` in XLEN, `commit_rob_id` in ROB_W: ROB commit
- `rename_valid` in 1, `rename_reg_id` in REG_W, `rename_rob_id` in ROB_W: new producer tag for a destination
- `rd_id` in NUM_RD*REG_W: packed read indices, channel k at bits [k*REG_W +: REG_W]
- `rd_val` out NUM_RD*XLEN, `rd_has_dep` out NUM_RD, `rd_dep` out NUM_RD*ROB_W: per-channel operand result
- `rob_qry_id` out NUM_RD*ROB_W: tag query to ROB, equals `rd_dep`
- `rob_qry_ready` in NUM_RD, `rob_qry_val` in NUM_RD*XLEN: ROB answer, same cycle
- `snap_save` in 1, `snap_save_slot` in SNAP_W: save checkpoint
- `snap_restore` in 1, `snap_restore_slot` in SNAP_W: restore checkpoint

## Operation
- State:
  - `regs[NUM_REGS]` (XLEN)
  - `dep[NUM_REGS]` (ROB_W)
  - `busy[NUM_REGS]`
  - snapshot arrays `s_dep[NUM_SNAP][NUM_REGS]` and `s_busy[NUM_SNAP][NUM_REGS]`
- Register 0: reads always value 0 with `has_dep` 0. Commits and renames targeting register 0 are ignored.
- Read channel k, combinational. Let r = `rd_id[k]`; `rd_dep[k]` = `dep[r]`.
  - `busy[r]` = 0: value = `regs[r]`, `has_dep` = 0.
  - Else if `commit_valid` and `commit_rob_id` == `dep[r]`: value = `commit_val`, `has_dep` = 0 (forward).
  - Else if `rob_qry_ready[k]`: value = `rob_qry_val[k]`, `has_dep` = 0.
  - Else: value = `regs[r]`, `has_dep` = 1.
- Commit (per cycle):
  - `regs[commit_reg_id]` ← `commit_val`.
  - `busy` is cleared only if `dep` == `commit_rob_id` and there is no same-cycle rename of the same register.
- Rename: `dep[reg]` ← tag, `busy[reg]` ← 1. A rename beats a same-cycle commit clear on the same register.
- Priority per edge: `rst_in` > !`rdy_in` > `rob_clear` > `snap_restore` > normal (commit + rename + `snap_save`).
  - `rst_in`: all state, snapshots included, zeroed.
  - `rob_clear`: `dep`/`busy`/all `s_busy` ← 0. The commit write to `regs` still happens. Rename, save and restore are ignored.
  - `snap_restore`: `dep`/`busy` ← slot contents, then this cycle's commit clear is applied to the restored table. Rename and save are ignored.
  - `snap_save`: slot ← live table after this cycle's rename and commit clear.
- Commit clear also applies to every snapshot slot whose entry for `commit_reg_id` holds `commit_rob_id`. Restored checkpoints therefore never resurrect retired tags.
- Restoring a never-saved slot yields an all-clear table.

## Timing
- Reads: zero latency, combinational from state and same-cycle commit/ROB inputs.
- Writes, renames, saves and restores are visible to reads from the cycle after the edge.
- A read in the same cycle as a rename of that register sees the old mapping.
- Reset values of outputs (follow from zeroed state): `rd_val` 0, `rd_has_dep` 0, `rd_dep` 0, `rob_qry_id` 0.
- While `rdy_in` is low, outputs keep tracking inputs combinationally; state is frozen.

## Configuration
- `RENAME_SNAPSHOT_EN` defined: snapshot arrays and save/restore logic are present, as specified above.
- Not defined:
  - no snapshot storage is generated
  - `snap_*` inputs are ignored
  - `NUM_SNAP` is unused
  - the priority chain reduces to `rst_in` > !`rdy_in` > `rob_clear` > normal
- Ports are identical in both builds.

## Test plan
- Reset, then read r5 on channels 0 and 1 → `rd_val` 0, `rd_has_dep` 0, `rd_dep` 0.
- Rename r5 → tag 3; next cycle read r5 with `rob_qry_ready` 0 → `has_dep` 1, `dep` 3. Commit r5 = 0xDEADBEEF tag 3 in that cycle → same-cycle `rd_val` 0xDEADBEEF, `has_dep` 0; the cycle after, `busy` is clear.
- Same cycle: commit r7 tag 2 plus rename r7 → tag 6 → next cycle `has_dep` 1, `dep` 6, `regs[7]` updated.
- Rename r0 → tag 1, commit r0 = 5 → r0 still reads 0 with `has_dep` 0.
- With `RENAME_SNAPSHOT_EN`: rename r3 → 4, save slot 1, rename r3 → 7, commit tag 4, restore slot 1 → r3 not busy and reads the committed value. Assert `rob_clear` together with `snap_restore` → all clear.
- Hold `rdy_in` low with a rename and commit applied → no state change; release → behaviour resumes normally.
